muldiv_ctrl: RTL and testbench

Sequencer that shares one HI/LO register pair between the 33-step Booth multiplier and the iterative divider in the multicycle CPU. It accepts one operation from the main control unit and latches operands. It holds the selected unit's enable for the unit's full step count, writes the result into HI/LO, and signals completion. It also handles MTHI/MTLO writes and divide-by-zero.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_if.sv | 44 ++++
 rtl/muldiv_step_counter.sv | 36 +++
 rtl/muldiv_ctrl.sv | 146 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op encoding, FSM states, default sizes.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  localparam int DEF_W           = 32;
  localparam int DEF_MULT_CYCLES = 33;
  localparam int DEF_DIV_CYCLES  = 33;
  localparam int DEF_CNT_W       = 6;

  typedef enum logic [1:0] {
    IDLE,
    MULT_RUN,
    DIV_RUN,
    WB
  } muldiv_state_t;

  function automatic int maxCycles(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Bus between the control unit / arithmetic units and the muldiv sequencer.
// Optional abort input is present only when MULDIV_ABORT_EN is defined.
interface muldiv_if import muldiv_pkg::*; #(parameter int W = DEF_W);

  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic [W-1:0] mult_hi_i;
  logic [W-1:0] mult_lo_i;
  logic [W-1:0] div_hi_i;
  logic [W-1:0] div_lo_i;
`ifdef MULDIV_ABORT_EN
  logic         abort_i;
`endif
  logic [W-1:0] opnd_a_o;
  logic [W-1:0] opnd_b_o;
  logic         mult_en_o;
  logic         div_en_o;
  logic         busy_o;
  logic         done_o;
  logic         div_zero_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  modport slave (
    input  start_i, op_i, a_i, b_i, mult_hi_i, mult_lo_i, div_hi_i, div_lo_i,
`ifdef MULDIV_ABORT_EN
    input  abort_i,
`endif
    output opnd_a_o, opnd_b_o, mult_en_o, div_en_o, busy_o, done_o, div_zero_o,
           hi_o, lo_o
  );

  modport master (
    output start_i, op_i, a_i, b_i, mult_hi_i, mult_lo_i, div_hi_i, div_lo_i,
`ifdef MULDIV_ABORT_EN
    output abort_i,
`endif
    input  opnd_a_o, opnd_b_o, mult_en_o, div_en_o, busy_o, done_o, div_zero_o,
           hi_o, lo_o
  );

endinterface

// File: rtl/muldiv_step_counter.sv
// Step counter for the muldiv sequencer; tc_o flags the last enabled step.
module muldiv_step_counter import muldiv_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over enable so an abort or a completed run always restarts at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == term_i);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer sharing one HI/LO pair between the Booth multiplier and the iterative divider.
// Define MULDIV_ABORT_EN to add an abort input that cancels a running operation.
module muldiv_ctrl import muldiv_pkg::*; #(
  parameter int W           = DEF_W,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  if ((1 << CNT_W) <= maxCycles(MULT_CYCLES, DIV_CYCLES)) begin : gCntWCheck
    $error("muldiv_ctrl: CNT_W too narrow for MULT_CYCLES/DIV_CYCLES");
  end

  muldiv_state_t state_q, state_d;
  logic          isDiv_q, isDiv_d;
  logic [W-1:0]  opndA_q, opndA_d;
  logic [W-1:0]  opndB_q, opndB_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic          done_q, done_d;
  logic          divZero_q, divZero_d;
  logic          cntClr;
  logic          cntEn;
  logic          cntTc;
  logic [CNT_W-1:0] cntTerm;

  assign cntTerm = isDiv_q ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

  muldiv_step_counter #(.CNT_W(CNT_W)) uStepCounter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cntClr),
    .en_i   (cntEn),
    .term_i (cntTerm),
    .tc_o   (cntTc)
  );

  always_comb begin
    state_d   = state_q;
    isDiv_d   = isDiv_q;
    opndA_d   = opndA_q;
    opndB_d   = opndB_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divZero_d = 1'b0;
    cntClr    = 1'b0;
    cntEn     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          cntClr = 1'b1;
          case (bus.op_i)
            OP_MULT: begin
              opndA_d = bus.a_i;
              opndB_d = bus.b_i;
              isDiv_d = 1'b0;
              state_d = MULT_RUN;
            end
            OP_DIV: begin
              // A zero divisor never reaches the divider; report it straight away.
              if (bus.b_i == '0) begin
                done_d    = 1'b1;
                divZero_d = 1'b1;
              end else begin
                opndA_d = bus.a_i;
                opndB_d = bus.b_i;
                isDiv_d = 1'b1;
                state_d = DIV_RUN;
              end
            end
            OP_MTHI: begin
              hi_d   = bus.a_i;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = bus.a_i;
              done_d = 1'b1;
            end
          endcase
        end
      end
      MULT_RUN, DIV_RUN: begin
        cntEn = 1'b1;
        if (cntTc) begin
          cntClr  = 1'b1;
          state_d = WB;
        end
      end
      WB: begin
        hi_d    = isDiv_q ? bus.div_hi_i : bus.mult_hi_i;
        lo_d    = isDiv_q ? bus.div_lo_i : bus.mult_lo_i;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
`ifdef MULDIV_ABORT_EN
    // Abort overrides everything outside IDLE, including the WB write-back.
    if (bus.abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
      cntClr  = 1'b1;
      cntEn   = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      isDiv_q   <= 1'b0;
      opndA_q   <= '0;
      opndB_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      isDiv_q   <= isDiv_d;
      opndA_q   <= opndA_d;
      opndB_q   <= opndB_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divZero_q <= divZero_d;
    end
  end

  assign bus.opnd_a_o   = opndA_q;
  assign bus.opnd_b_o   = opndB_q;
  assign bus.mult_en_o  = (state_q == MULT_RUN);
  assign bus.div_en_o   = (state_q == DIV_RUN);
  assign bus.busy_o     = (state_q != IDLE);
  assign bus.done_o     = done_q;
  assign bus.div_zero_o = divZero_q;
  assign bus.hi_o       = hi_q;
  assign bus.lo_o       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with stub multiplier/divider and an expected-result scoreboard.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  exp_t sb[$];
  int   checks  = 0;
  int   passed  = 0;
  int   fails   = 0;
  int   doneSeen = 0;
  int   expDone  = 0;

  muldiv_if #(.W(32)) bus ();

  muldiv_ctrl #(.W(32), .MULT_CYCLES(33), .DIV_CYCLES(33), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Stub units: garbage while loading, real result only after the 33rd enabled edge.
  int          mCnt, dCnt;
  logic [63:0] mRes, dRes;

  function automatic logic [63:0] mulModel(input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv;
    sa  = $signed(a);
    sbv = $signed(b);
    return 64'(sa * sbv);
  endfunction

  function automatic logic [63:0] divModel(input logic [31:0] a, input logic [31:0] b);
    int q, r;
    if (b == 32'd0) return 64'hDEAD_0000_DEAD_0000;
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {32'(r), 32'(q)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mCnt <= 0;
      mRes <= '0;
    end else if (bus.mult_en_o) begin
      mCnt <= mCnt + 1;
      if (mCnt == 0) mRes <= 64'hA5A5_A5A5_5A5A_5A5A;
      else if (mCnt == 32) mRes <= mulModel(bus.opnd_a_o, bus.opnd_b_o);
    end else begin
      mCnt <= 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dCnt <= 0;
      dRes <= '0;
    end else if (bus.div_en_o) begin
      dCnt <= dCnt + 1;
      if (dCnt == 0) dRes <= 64'h5A5A_5A5A_A5A5_A5A5;
      else if (dCnt == 32) dRes <= divModel(bus.opnd_a_o, bus.opnd_b_o);
    end else begin
      dCnt <= 0;
    end
  end

  assign bus.mult_hi_i = mRes[63:32];
  assign bus.mult_lo_i = mRes[31:0];
  assign bus.div_hi_i  = dRes[63:32];
  assign bus.div_lo_i  = dRes[31:0];

  always @(negedge clk) if (bus.done_o === 1'b1) doneSeen++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; the request is sampled at the following rising edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
  endtask

  task automatic checkOutput(input string tag, input int expLat, input int expMultEn,
                             input int expDivEn, input int injectAt,
                             input logic [31:0] expOpA, input logic [31:0] expOpB);
    int   cyc = 0;
    int   mEn = 0;
    int   dEn = 0;
    bit   busySeen = 1'b0;
    bit   got = 1'b0;
    exp_t e;
    expDone++;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) bus.start_i = 1'b0;
      if (injectAt > 0 && cyc == injectAt) applyStimulus(OP_DIV, 32'd99, 32'd3);
      if (injectAt > 0 && cyc == injectAt + 1) bus.start_i = 1'b0;
      if (injectAt > 0 && cyc == injectAt + 2) begin
        check({tag, " opnd_a hold"}, 64'(bus.opnd_a_o), 64'(expOpA));
        check({tag, " opnd_b hold"}, 64'(bus.opnd_b_o), 64'(expOpB));
      end
      mEn += int'(bus.mult_en_o);
      dEn += int'(bus.div_en_o);
      if (bus.done_o === 1'b1) got = 1'b1;
      else if (bus.busy_o === 1'b1) busySeen = 1'b1;
    end
    check({tag, " done seen"}, 64'(got), 64'd1);
    if (sb.size() == 0) begin
      check({tag, " scoreboard entry"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      if (got) begin
        check({tag, " latency"}, 64'(cyc), 64'(expLat));
        check({tag, " hi"}, 64'(bus.hi_o), 64'(e.hi));
        check({tag, " lo"}, 64'(bus.lo_o), 64'(e.lo));
        check({tag, " div_zero"}, 64'(bus.div_zero_o), 64'(e.dz));
        check({tag, " busy at done"}, 64'(bus.busy_o), 64'd0);
        check({tag, " mult_en cycles"}, 64'(mEn), 64'(expMultEn));
        check({tag, " div_en cycles"}, 64'(dEn), 64'(expDivEn));
        check({tag, " busy seen"}, 64'(busySeen), 64'(expLat > 1));
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit busyAny;
    bus.start_i = 1'b0;
    bus.op_i    = 2'b00;
    bus.a_i     = '0;
    bus.b_i     = '0;
`ifdef MULDIV_ABORT_EN
    bus.abort_i = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #2;
    check("reset busy", 64'(bus.busy_o), 64'd0);
    check("reset done", 64'(bus.done_o), 64'd0);
    check("reset mult_en", 64'(bus.mult_en_o), 64'd0);
    check("reset div_en", 64'(bus.div_en_o), 64'd0);
    check("reset hi", 64'(bus.hi_o), 64'd0);
    check("reset lo", 64'(bus.lo_o), 64'd0);
    check("reset opnd_a", 64'(bus.opnd_a_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
    applyStimulus(OP_MULT, 32'd7, 32'hFFFF_FFFD);
    checkOutput("mult 7*-3", 35, 33, 0, 0, 32'd0, 32'd0);

    sb.push_back('{32'd2, 32'd14, 1'b0});
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    checkOutput("div 100/7", 35, 0, 33, 0, 32'd0, 32'd0);

    sb.push_back('{32'd2, 32'd14, 1'b1});
    applyStimulus(OP_DIV, 32'd5, 32'd0);
    checkOutput("div by zero", 1, 0, 0, 0, 32'd0, 32'd0);

    sb.push_back('{32'hDEAD_BEEF, 32'd14, 1'b0});
    applyStimulus(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    checkOutput("mthi", 1, 0, 0, 0, 32'd0, 32'd0);

    sb.push_back('{32'hDEAD_BEEF, 32'h1234_5678, 1'b0});
    applyStimulus(OP_MTLO, 32'h1234_5678, 32'd0);
    checkOutput("mtlo", 1, 0, 0, 0, 32'd0, 32'd0);

    sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFE2, 1'b0});
    applyStimulus(OP_MULT, 32'hFFFF_FFFB, 32'd6);
    checkOutput("mult ignore start", 35, 33, 0, 10, 32'hFFFF_FFFB, 32'd6);
    busyAny = 1'b0;
    repeat (40) begin
      @(negedge clk);
      busyAny |= bus.busy_o;
    end
    check("ignored start not queued", 64'(busyAny), 64'd0);
    check("done pulse count", 64'(doneSeen), 64'(expDone));

    applyStimulus(OP_MULT, 32'd3, 32'd4);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset mult_en", 64'(bus.mult_en_o), 64'd0);
    check("async reset busy", 64'(bus.busy_o), 64'd0);
    check("async reset hi", 64'(bus.hi_o), 64'd0);
    check("async reset lo", 64'(bus.lo_o), 64'd0);
    check("async reset opnd_b", 64'(bus.opnd_b_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{32'd0, 32'd144, 1'b0});
    applyStimulus(OP_MULT, 32'd12, 32'd12);
    checkOutput("mult after reset", 35, 33, 0, 0, 32'd0, 32'd0);

`ifdef MULDIV_ABORT_EN
    applyStimulus(OP_DIV, 32'd50, 32'd5);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) bus.start_i = 1'b0;
    end
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    check("abort busy", 64'(bus.busy_o), 64'd0);
    check("abort div_en", 64'(bus.div_en_o), 64'd0);
    repeat (40) @(negedge clk);
    check("abort no done", 64'(doneSeen), 64'(expDone));
    check("abort hi", 64'(bus.hi_o), 64'd0);
    check("abort lo", 64'(bus.lo_o), 64'd144);
    sb.push_back('{32'd0, 32'd81, 1'b0});
    applyStimulus(OP_MULT, 32'd9, 32'd9);
    checkOutput("mult after abort", 35, 33, 0, 0, 32'd0, 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("final done pulse count", 64'(doneSeen), 64'(expDone));
    check("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
